// File: rtl/seg_bcd_display.sv
// Binary-to-seven-segment driver: sequential double-dabble (decimal) or direct hex digits,
// registered active-low segment bytes with overflow dashes. Optional macro: SEG_BLANK_LZ_EN.
module seg_bcd_display #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  hex_mode,
  output logic [8*DIGITS-1:0]   o_seg,
  output logic                  overflow,
  output logic                  done
);

  localparam int unsigned NB = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  state_t              state_q, state_d;
  logic                accept, shift_en, update_en;

  logic [WIDTH-1:0]    data_q;
  logic                hex_q;
  logic [NB-1:0]       bcd_q, bcd_d, adj;
  logic                ovf_q;
  logic [CW-1:0]       cnt_q;
  logic [8*DIGITS-1:0] seg_q, seg_d;
  logic                overflow_q, done_q;

  logic [WIDTH+NB-1:0] ext;
  logic [NB-1:0]       src;
  logic                hex_ovf, disp_ovf;
  logic [DIGITS-1:0]   blank;

  function automatic logic [7:0] seg_lut(input logic [3:0] d);
    case (d)
      4'h0: seg_lut = 8'hC0;
      4'h1: seg_lut = 8'hF9;
      4'h2: seg_lut = 8'hA4;
      4'h3: seg_lut = 8'hB0;
      4'h4: seg_lut = 8'h99;
      4'h5: seg_lut = 8'h92;
      4'h6: seg_lut = 8'h82;
      4'h7: seg_lut = 8'hF8;
      4'h8: seg_lut = 8'h80;
      4'h9: seg_lut = 8'h90;
      4'hA: seg_lut = 8'h88;
      4'hB: seg_lut = 8'h83;
      4'hC: seg_lut = 8'hC6;
      4'hD: seg_lut = 8'hA1;
      4'hE: seg_lut = 8'h86;
      default: seg_lut = 8'h8E;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = hex_mode ? UPDATE : SHIFT;
      SHIFT:   if (cnt_q == CW'(1)) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    accept    = in_ready && in_valid;
    shift_en  = (state_q == SHIFT);
    update_en = (state_q == UPDATE);
  end

  // Add-3 correction precedes the shift; the bit leaving the top digit marks overflow.
  always_comb begin
    adj = bcd_q;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    bcd_d = {adj[NB-2:0], data_q[WIDTH-1]};
  end

  // Zero-extension makes the hex high-bit check vanish when all bits fit in the display.
  assign ext      = {{NB{1'b0}}, data_q};
  assign hex_ovf  = |ext[WIDTH+NB-1:NB];
  assign src      = hex_q ? ext[NB-1:0] : bcd_q;
  assign disp_ovf = hex_q ? hex_ovf : ovf_q;

`ifdef SEG_BLANK_LZ_EN
  always_comb begin
    logic seen;
    seen     = 1'b0;
    blank    = '0;
    for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
      if (src[4*k +: 4] != 4'd0) seen = 1'b1;
      blank[k] = !seen;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    seg_d = '1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (disp_ovf)      seg_d[8*k +: 8] = 8'hBF;
      else if (blank[k]) seg_d[8*k +: 8] = 8'hFF;
      else               seg_d[8*k +: 8] = seg_lut(src[4*k +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      hex_q      <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      seg_q      <= '1;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= update_en;
      if (accept) begin
        data_q <= in_data;
        hex_q  <= hex_mode;
        bcd_q  <= '0;
        ovf_q  <= 1'b0;
        cnt_q  <= CW'(WIDTH);
      end
      if (shift_en) begin
        data_q <= data_q << 1;
        bcd_q  <= bcd_d;
        ovf_q  <= ovf_q | adj[NB-1];
        cnt_q  <= cnt_q - CW'(1);
      end
      if (update_en) begin
        seg_q      <= seg_d;
        overflow_q <= disp_ovf;
      end
    end
  end

  assign o_seg    = seg_q;
  assign overflow = overflow_q;
  assign done     = done_q;

endmodule
